video_pattern_gen: RTL and testbench
====================================

# video_pattern_gen

Source-side video stream generator: produces the frame-timed RGB565 `vs`/`de`/`data` stream that the video-processing chain consumes on its `vi_*` inputs. It is used for bring-up and bench stimulus in place of a camera/DVP front end. It generates standard-style blanking timing with selectable test patterns, and latches all configuration only at frame boundaries.

## Interface
- `H_DISP`, 1280: active pixels per line
- `V_DISP`, 720: active lines per frame
- `H_FRONT` / `H_SYNC` / `H_BACK`, 110 / 40 / 220: horizontal blanking segments, in clocks
- `V_FRONT` / `V_SYNC` / `V_BACK`, 5 / 5 / 20: vertical blanking segments, in lines
- `X_WIDTH` / `Y_WIDTH`, 12 / 12: counter widths; must hold H_TOTAL-1 and V_TOTAL-1
- `clk`  in  1  pixel clock; the only clock
- `rst_n`  in  1  asynchronous, active-low reset
- `EN`  in  1  generator enable, sampled at frame boundary
- `mode`  in  2  00 colour bars, 01 grid, 10 gradient, 11 solid; sampled at frame boundary
- `solid_color`  in  16  RGB565 value for mode 11; sampled at frame boundary
- `post_hs`  out  1  horizontal sync, active high
- `post_vs`  out  1  vertical sync, active high
- `post_de`  out  1  active-pixel strobe
- `post_data`  out  16  RGB565 pixel; 0 whenever `post_de`=0

## Operation
- H_TOTAL = H_DISP+H_FRONT+H_SYNC+H_BACK (1650). V_TOTAL is formed the same way from the vertical segments (750).
- Counters: `h_cnt` runs 0..H_TOTAL-1 and wraps to 0. `v_cnt` increments on each `h_cnt` wrap and wraps after V_TOTAL-1.
- Active region: `h_cnt`<H_DISP and `v_cnt`<V_DISP. x=`h_cnt`, y=`v_cnt`.
- `hs` is high for `h_cnt` in [H_DISP+H_FRONT, H_DISP+H_FRONT+H_SYNC), i.e. [1390,1430). `vs` is high for `v_cnt` in [V_DISP+V_FRONT, V_DISP+V_FRONT+V_SYNC), i.e. [725,730). `hs` toggles on every line, including blanking lines.
- Frame boundary: the cycle where `h_cnt`=H_TOTAL-1 and `v_cnt`=V_TOTAL-1. Idle with EN=1 is also treated as a frame boundary.
- States:
  - IDLE: counters held at 0, all outputs 0. Goes to RUN in the cycle EN is sampled high.
  - RUN: counters free-run. At each frame boundary, EN, `mode` and `solid_color` are re-latched. If the latched EN is 0, the block returns to IDLE instead of wrapping.
- EN dropping mid-frame completes the current frame. It never truncates a line or frame. Mid-frame `mode` changes take effect on the next frame.
- Patterns:
  - Colour bars: 8 bars of BAR_W=H_DISP/8 pixels, integer division; the last bar absorbs the remainder. Order is FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. The bar index comes from a bar-position counter reset at BAR_W, with no divider, and is cleared at the start of each line.
  - Grid: FFFF where (x+s)[4:0]==0 or y[4:0]==0, else 0000.
  - Gradient: {(x+s)[7:3], y[7:2], x[9:5]}.
  - Solid: the latched `solid_color`.
  - s is the scroll offset (see Configuration). Additions are truncated to X_WIDTH.

## Timing
- Reset: all outputs 0, counters 0, state IDLE, latched mode 00, scroll offset 0.
- All outputs are registered. Exactly 1 clock of latency from counter state to `post_*`, so `hs`, `vs`, `de` and `data` are mutually aligned.
- First `post_de` appears 2 clocks after EN is first sampled high in IDLE: EN is sampled, RUN is entered with counters at 0, then the registered output follows.
- `post_de` is high for exactly H_DISP consecutive clocks per active line, on V_DISP lines per frame, giving 921600 `de` cycles per frame at the defaults.
- Reset asserted mid-frame: outputs drop to 0 immediately (asynchronously). After release, the block restarts from IDLE.

## Configuration
- `VIDEO_PATTERN_GEN_SCROLL_EN` defined: an 8-bit scroll offset s increments by 1 at every frame boundary in RUN, wraps 255→0, and clears in IDLE. Grid and gradient scroll horizontally by 1 pixel per frame.
- Macro undefined: s is a constant 0, the offset register is absent, and the patterns are static.

## Structure
- Package `video_pattern_pkg` holds:
  - mode encodings (MODE_BARS, MODE_GRID, MODE_GRAD, MODE_SOLID)
  - the eight RGB565 bar-colour constants
  - a function computing H_TOTAL/V_TOTAL from the segment parameters
- Sub-module `video_timing_core` holds the h/v counters, the IDLE/RUN state, the frame-boundary strobe, x/y and raw hs/vs/de. The top-level adds pattern muxing and output registers.

## Test plan
- Reset, then EN=1, mode=00: first `post_de` 2 clocks after EN. `post_data` is FFFF for x 0..159, FFE0 for x 160..319, and so on, with 0000 for x 1120..1279.
- Count over one frame: exactly 921600 `de` cycles, `hs` high 40 clocks per line at `h_cnt` 1390..1429, `vs` high for lines 725..729, and 1650×750 clocks per frame.
- `mode` changed 00→11 with `solid_color`=1234 mid-frame: bars continue to the frame end, and the next frame is all 1234 on every `de` pixel.
- EN dropped at line 100: the frame completes through `v_cnt`=749, the block then enters IDLE with all outputs 0, and no partial frame is produced.
- `rst_n` pulsed low at line 300: outputs are 0 during reset. After release with EN=1, timing restarts at x=0, y=0.
- With `VIDEO_PATTERN_GEN_SCROLL_EN` and mode=01: frame 0 has white columns at x=0,32,…; frame 1 has them at x=31,63,…; the pattern repeats after 256 frames.

Source files
------------

// File: rtl/video_pattern_pkg.sv
// Shared definitions for the video pattern generator: mode encodings,
// generator state encoding, the RGB565 colour-bar palette and a helper
// that totals a set of blanking segments into a line or frame period.
package video_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'b00,
    MODE_GRID  = 2'b01,
    MODE_GRAD  = 2'b10,
    MODE_SOLID = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Colour-bar palette, left to right across the active line.
  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  // Period of a line (clocks) or frame (lines) from its four segments.
  function automatic int seg_total(input int disp, input int front,
                                   input int sync, input int back);
    return disp + front + sync + back;
  endfunction

  // Palette lookup by bar index.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_core.sv
// Raster timing core: IDLE/RUN control, free-running h/v counters, the
// frame-boundary configuration strobe and unregistered hs/vs/de.
// All raster outputs are forced low while IDLE.
module video_timing_core
  import video_pattern_pkg::*;
#(
  parameter int H_DISP  = 1280,
  parameter int V_DISP  = 720,
  parameter int H_FRONT = 110,
  parameter int H_SYNC  = 40,
  parameter int H_BACK  = 220,
  parameter int V_FRONT = 5,
  parameter int V_SYNC  = 5,
  parameter int V_BACK  = 20,
  parameter int X_WIDTH = 12,
  parameter int Y_WIDTH = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               run,
  output logic               cfg_load,
  output logic               line_last,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               hs,
  output logic               vs,
  output logic               de
);

  localparam int H_TOTAL = seg_total(H_DISP, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = seg_total(V_DISP, V_FRONT, V_SYNC, V_BACK);

  localparam logic [X_WIDTH-1:0] H_LAST   = X_WIDTH'(H_TOTAL - 1);
  localparam logic [Y_WIDTH-1:0] V_LAST   = Y_WIDTH'(V_TOTAL - 1);
  localparam logic [X_WIDTH-1:0] H_ACT    = X_WIDTH'(H_DISP);
  localparam logic [Y_WIDTH-1:0] V_ACT    = Y_WIDTH'(V_DISP);
  localparam logic [X_WIDTH-1:0] HS_START = X_WIDTH'(H_DISP + H_FRONT);
  localparam logic [X_WIDTH-1:0] HS_END   = X_WIDTH'(H_DISP + H_FRONT + H_SYNC);
  localparam logic [Y_WIDTH-1:0] VS_START = Y_WIDTH'(V_DISP + V_FRONT);
  localparam logic [Y_WIDTH-1:0] VS_END   = Y_WIDTH'(V_DISP + V_FRONT + V_SYNC);

  state_e             state_reg, state_next;
  logic [X_WIDTH-1:0] h_cnt_reg, h_cnt_next;
  logic [Y_WIDTH-1:0] v_cnt_reg, v_cnt_next;
  logic               h_wrap, v_wrap;

  assign run       = (state_reg == ST_RUN);
  assign h_wrap    = (h_cnt_reg == H_LAST);
  assign v_wrap    = (v_cnt_reg == V_LAST);
  assign line_last = run && h_wrap;
  // Idle with EN high counts as a frame boundary so the first frame
  // starts with freshly latched configuration.
  assign cfg_load  = run ? (h_wrap && v_wrap) : en;

  assign x  = h_cnt_reg;
  assign y  = v_cnt_reg;
  assign hs = run && (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END);
  assign vs = run && (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END);
  assign de = run && (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);

  // State and raster counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  // Counter advance and IDLE/RUN decisions; EN only matters at frame ends
  // so a frame is never cut short.
  always_comb begin
    state_next = state_reg;
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        h_cnt_next = '0;
        v_cnt_next = '0;
        if (en) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (h_wrap) begin
          h_cnt_next = '0;
          if (v_wrap) begin
            v_cnt_next = '0;
            if (!en) state_next = ST_IDLE;
          end else begin
            v_cnt_next = v_cnt_reg + Y_WIDTH'(1);
          end
        end else begin
          h_cnt_next = h_cnt_reg + X_WIDTH'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        h_cnt_next = '0;
        v_cnt_next = '0;
      end
    endcase
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source producing RGB565 with hs/vs/de timing.
// Mode and solid colour are latched at frame boundaries only.
// Optional build macro VIDEO_PATTERN_GEN_SCROLL_EN adds an 8-bit
// per-frame horizontal scroll to the grid and gradient patterns.
module video_pattern_gen
  import video_pattern_pkg::*;
#(
  parameter int H_DISP  = 1280,
  parameter int V_DISP  = 720,
  parameter int H_FRONT = 110,
  parameter int H_SYNC  = 40,
  parameter int H_BACK  = 220,
  parameter int V_FRONT = 5,
  parameter int V_SYNC  = 5,
  parameter int V_BACK  = 20,
  parameter int X_WIDTH = 12,
  parameter int Y_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EN,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        post_hs,
  output logic        post_vs,
  output logic        post_de,
  output logic [15:0] post_data
);

  localparam int BAR_W = H_DISP / 8;
  localparam logic [X_WIDTH-1:0] BAR_LAST = X_WIDTH'(BAR_W - 1);

  logic               run, cfg_load, line_last;
  logic               hs_raw, vs_raw, de_raw;
  logic [X_WIDTH-1:0] x;
  logic [Y_WIDTH-1:0] y;

  video_timing_core #(
    .H_DISP  (H_DISP),
    .V_DISP  (V_DISP),
    .H_FRONT (H_FRONT),
    .H_SYNC  (H_SYNC),
    .H_BACK  (H_BACK),
    .V_FRONT (V_FRONT),
    .V_SYNC  (V_SYNC),
    .V_BACK  (V_BACK),
    .X_WIDTH (X_WIDTH),
    .Y_WIDTH (Y_WIDTH)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (EN),
    .run       (run),
    .cfg_load  (cfg_load),
    .line_last (line_last),
    .x         (x),
    .y         (y),
    .hs        (hs_raw),
    .vs        (vs_raw),
    .de        (de_raw)
  );

  mode_e       mode_reg;
  logic [15:0] solid_reg;

  // Configuration latched only at frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg  <= MODE_BARS;
      solid_reg <= '0;
    end else if (cfg_load) begin
      mode_reg  <= mode_e'(mode);
      solid_reg <= solid_color;
    end
  end

  logic [7:0] scroll;

`ifdef VIDEO_PATTERN_GEN_SCROLL_EN
  logic [7:0] scroll_reg;

  // Scroll offset: cleared while idle, steps once per completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll_reg <= '0;
    end else if (!run) begin
      scroll_reg <= '0;
    end else if (cfg_load) begin
      scroll_reg <= scroll_reg + 8'd1;
    end
  end

  assign scroll = scroll_reg;
`else
  assign scroll = 8'd0;
`endif

  logic [X_WIDTH-1:0] bar_cnt_reg;
  logic [2:0]         bar_idx_reg;

  // Bar position tracks x without a divider; the final bar stops advancing
  // so it absorbs any remainder of the active width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_cnt_reg <= '0;
      bar_idx_reg <= '0;
    end else if (!run || line_last) begin
      bar_cnt_reg <= '0;
      bar_idx_reg <= '0;
    end else if (bar_idx_reg != 3'd7) begin
      if (bar_cnt_reg == BAR_LAST) begin
        bar_cnt_reg <= '0;
        bar_idx_reg <= bar_idx_reg + 3'd1;
      end else begin
        bar_cnt_reg <= bar_cnt_reg + X_WIDTH'(1);
      end
    end
  end

  logic [X_WIDTH-1:0] xs;
  logic [15:0]        pixel;
  logic               unused_bits;

  assign xs          = x + X_WIDTH'(scroll);
  assign unused_bits = ^{xs[X_WIDTH-1:8], y[Y_WIDTH-1:8]};

  // Pattern selection from the latched mode.
  always_comb begin
    pixel = 16'h0000;
    case (mode_reg)
      MODE_BARS:  pixel = bar_color(bar_idx_reg);
      MODE_GRID:  pixel = ((xs[4:0] == 5'd0) || (y[4:0] == 5'd0)) ? 16'hFFFF : 16'h0000;
      MODE_GRAD:  pixel = {xs[7:3], y[7:2], x[9:5]};
      MODE_SOLID: pixel = solid_reg;
      default:    pixel = 16'h0000;
    endcase
  end

  // One-clock output stage keeps sync, strobe and data aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_hs   <= 1'b0;
      post_vs   <= 1'b0;
      post_de   <= 1'b0;
      post_data <= 16'h0000;
    end else begin
      post_hs   <= hs_raw;
      post_vs   <= vs_raw;
      post_de   <= de_raw;
      post_data <= de_raw ? pixel : 16'h0000;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen using a reduced raster so whole
// frames fit in a short run. Expected outputs come from an arithmetic model
// of the raster (cycle index -> position -> pattern value).
module tb_video_pattern_gen;

  localparam int HD = 70, HF = 4, HSY = 4, HB = 8;
  localparam int VD = 40, VF = 2, VSY = 2, VB = 4;
  localparam int HT = HD + HF + HSY + HB;
  localparam int VT = VD + VF + VSY + VB;
  localparam int FR = HT * VT;

  logic        clk;
  logic        rst_n;
  logic        EN;
  logic [1:0]  mode;
  logic [15:0] solid_color;
  logic        post_hs, post_vs, post_de;
  logic [15:0] post_data;

  int checks, passed;

  // model state
  bit          m_active;
  int          m_k;
  int          m_frame;
  logic [1:0]  m_mode;
  logic [15:0] m_solid;

  // per-window statistics
  int          err_cnt, de_cnt, hs_cnt, vs_cnt, val_cnt;
  logic [15:0] watch_val;
  string       first_err;

  video_pattern_gen #(
    .H_DISP(HD), .V_DISP(VD),
    .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .X_WIDTH(12), .Y_WIDTH(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .EN(EN), .mode(mode), .solid_color(solid_color),
    .post_hs(post_hs), .post_vs(post_vs), .post_de(post_de), .post_data(post_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // Expected {hs, vs, de, data} for the k-th clock of a running stream.
  function automatic logic [18:0] model_out(input int k, input logic [1:0] md,
                                            input logic [15:0] sc, input int s);
    int r, h, v, xs, bar;
    logic hs, vs, de;
    logic [15:0] d;
    logic [11:0] xsv, vv, hv;
    r  = k % FR;
    h  = r % HT;
    v  = r / HT;
    hs = (h >= HD + HF) && (h < HD + HF + HSY);
    vs = (v >= VD + VF) && (v < VD + VF + VSY);
    de = (h < HD) && (v < VD);
    xs = (h + s) % 4096;
    xsv = 12'(xs);
    vv  = 12'(v);
    hv  = 12'(h);
    d = 16'h0000;
    if (de) begin
      case (md)
        2'd0: begin
          bar = h / (HD / 8);
          if (bar > 7) bar = 7;
          case (bar)
            0: d = 16'hFFFF;
            1: d = 16'hFFE0;
            2: d = 16'h07FF;
            3: d = 16'h07E0;
            4: d = 16'hF81F;
            5: d = 16'hF800;
            6: d = 16'h001F;
            default: d = 16'h0000;
          endcase
        end
        2'd1: d = (((xs % 32) == 0) || ((v % 32) == 0)) ? 16'hFFFF : 16'h0000;
        2'd2: d = {xsv[7:3], vv[7:2], hv[9:5]};
        default: d = sc;
      endcase
    end
    return {hs, vs, de, d};
  endfunction

  task automatic clear_stats();
    err_cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; val_cnt = 0;
    first_err = "none";
  endtask

  // Advance one clock: predict the registered outputs, update the model's
  // notion of where the stream is, then score the DUT on the falling edge.
  task automatic cycle();
    logic [18:0] exp_v, act_v;
    int s;
`ifdef VIDEO_PATTERN_GEN_SCROLL_EN
    s = m_frame % 256;
`else
    s = 0;
`endif
    exp_v = m_active ? model_out(m_k, m_mode, m_solid, s) : 19'd0;
    if (!m_active) begin
      if (EN) begin
        m_active = 1'b1; m_k = 0; m_frame = 0; m_mode = mode; m_solid = solid_color;
      end
    end else if ((m_k % FR) == FR - 1) begin
      if (EN) begin
        m_k++; m_frame++; m_mode = mode; m_solid = solid_color;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_k++;
    end
    @(posedge clk);
    @(negedge clk);
    act_v = {post_hs, post_vs, post_de, post_data};
    if (act_v !== exp_v) begin
      if (err_cnt == 0)
        first_err = $sformatf("t=%0t got %h want %h", $time, act_v, exp_v);
      err_cnt++;
    end
    if (post_de === 1'b1) de_cnt++;
    if (post_hs === 1'b1) hs_cnt++;
    if (post_vs === 1'b1) vs_cnt++;
    if (post_de === 1'b1 && post_data === watch_val) val_cnt++;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; EN = 1'b0; mode = 2'd0; solid_color = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({post_hs, post_vs, post_de, post_data} !== 19'd0)
      $display("FAIL reset_outputs: got %h want 0", {post_hs, post_vs, post_de, post_data});
    else passed++;
    rst_n = 1'b1;
    clear_stats();
    run_cycles(20);
    checks++;
    if (err_cnt != 0 || de_cnt != 0)
      $display("FAIL idle_quiet: got errs=%0d de=%0d want 0/0 (%s)", err_cnt, de_cnt, first_err);
    else passed++;
    $display("test_reset done");
  endtask

  task automatic test_bars_timing();
    mode = 2'd0; solid_color = 16'($urandom); EN = 1'b1;
    clear_stats();
    cycle();
    checks++;
    if (post_de !== 1'b0) $display("FAIL de_latency_1: got %b want 0", post_de);
    else passed++;
    cycle();
    checks++;
    if ({post_de, post_data} !== {1'b1, 16'hFFFF})
      $display("FAIL first_de: got de=%b data=%h want de=1 data=ffff", post_de, post_data);
    else passed++;
    run_cycles(FR - 1);
    checks++;
    if (err_cnt != 0) $display("FAIL bars_frame: got %0d errors want 0 (%s)", err_cnt, first_err);
    else passed++;
    checks++;
    if (de_cnt != HD * VD) $display("FAIL de_count: got %0d want %0d", de_cnt, HD * VD);
    else passed++;
    checks++;
    if (hs_cnt != HSY * VT) $display("FAIL hs_count: got %0d want %0d", hs_cnt, HSY * VT);
    else passed++;
    checks++;
    if (vs_cnt != VSY * HT) $display("FAIL vs_count: got %0d want %0d", vs_cnt, VSY * HT);
    else passed++;
    $display("test_bars_timing done");
  endtask

  task automatic test_mode_switch();
    clear_stats();
    run_cycles(10 * HT);
    mode = 2'd3; solid_color = 16'h1234;
    run_cycles(FR - 10 * HT);
    checks++;
    if (err_cnt != 0) $display("FAIL bars_to_frame_end: got %0d errors want 0 (%s)", err_cnt, first_err);
    else passed++;
    clear_stats();
    watch_val = 16'h1234;
    run_cycles(10 * HT);
    mode = 2'd1;
    run_cycles(FR - 10 * HT);
    checks++;
    if (err_cnt != 0) $display("FAIL solid_frame: got %0d errors want 0 (%s)", err_cnt, first_err);
    else passed++;
    checks++;
    if (val_cnt != HD * VD) $display("FAIL solid_pixels: got %0d want %0d", val_cnt, HD * VD);
    else passed++;
    $display("test_mode_switch done");
  endtask

  task automatic test_random_modes();
    logic [1:0] next_mode [3];
    next_mode[0] = 2'd2;
    next_mode[1] = 2'($urandom_range(0, 3));
    next_mode[2] = 2'd0;
    for (int f = 0; f < 3; f++) begin
      clear_stats();
      run_cycles(5 * HT);
      mode = next_mode[f];
      solid_color = 16'($urandom);
      run_cycles(FR - 5 * HT);
      checks++;
      if (err_cnt != 0)
        $display("FAIL pattern_frame%0d: got %0d errors want 0 (%s)", f + 3, err_cnt, first_err);
      else passed++;
    end
    $display("test_random_modes done");
  endtask

  task automatic test_en_drop();
    clear_stats();
    run_cycles(10 * HT);
    EN = 1'b0;
    run_cycles(FR - 10 * HT);
    checks++;
    if (err_cnt != 0) $display("FAIL drop_frame: got %0d errors want 0 (%s)", err_cnt, first_err);
    else passed++;
    checks++;
    if (de_cnt != HD * VD) $display("FAIL drop_de_count: got %0d want %0d", de_cnt, HD * VD);
    else passed++;
    clear_stats();
    run_cycles(3 * HT);
    checks++;
    if (err_cnt != 0) $display("FAIL idle_after_drop: got %0d errors want 0 (%s)", err_cnt, first_err);
    else passed++;
    checks++;
    if (de_cnt + hs_cnt + vs_cnt != 0)
      $display("FAIL idle_activity: got de=%0d hs=%0d vs=%0d want 0", de_cnt, hs_cnt, vs_cnt);
    else passed++;
    $display("test_en_drop done");
  endtask

  task automatic test_reset_midframe();
    mode = 2'($urandom_range(0, 3)); solid_color = 16'($urandom); EN = 1'b1;
    clear_stats();
    run_cycles(2 + 30 * HT + 10);
    checks++;
    if (post_de !== 1'b1 || err_cnt != 0)
      $display("FAIL pre_reset_active: got de=%b errs=%0d want de=1 errs=0 (%s)", post_de, err_cnt, first_err);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({post_hs, post_vs, post_de, post_data} !== 19'd0)
      $display("FAIL async_reset_clear: got %h want 0", {post_hs, post_vs, post_de, post_data});
    else passed++;
    m_active = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({post_hs, post_vs, post_de, post_data} !== 19'd0)
      $display("FAIL reset_hold: got %h want 0", {post_hs, post_vs, post_de, post_data});
    else passed++;
    rst_n = 1'b1;
    clear_stats();
    cycle();
    cycle();
    checks++;
    if (post_de !== 1'b1) $display("FAIL restart_first_de: got %b want 1", post_de);
    else passed++;
    run_cycles(3 * HT);
    checks++;
    if (err_cnt != 0) $display("FAIL restart_lines: got %0d errors want 0 (%s)", err_cnt, first_err);
    else passed++;
    $display("test_reset_midframe done");
  endtask

  initial begin
    checks = 0; passed = 0;
    m_active = 1'b0; m_k = 0; m_frame = 0; m_mode = 2'd0; m_solid = 16'h0000;
    watch_val = 16'h0000;
    rst_n = 1'b0; EN = 1'b0; mode = 2'd0; solid_color = 16'h0000;
    test_reset();
    test_bars_timing();
    test_mode_switch();
    test_random_modes();
    test_en_drop();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
